// File: rtl/hypot_seq_if.sv
// Handshake and data bundle for the sequential Euclidean-magnitude unit.
// The requester drives operands and out_ready; the unit drives status and results.
interface hypot_seq_if #(
  parameter int W = 8
);
  localparam int RW = W + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          exact;
  logic          busy;

  modport master (
    output in_valid, x, y, mode, out_ready,
    input  in_ready, out_valid, result, exact, busy
  );

  modport slave (
    input  in_valid, x, y, mode, out_ready,
    output in_ready, out_valid, result, exact, busy
  );
endinterface

// File: rtl/hypot_seq.sv
// Sequential sqrt(x^2 + y^2): shift-add squaring of x then y into one
// accumulator, followed by a bit-serial restoring square root (one bit per
// cycle), with optional round-to-nearest and a perfect-square flag.
module hypot_seq #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  hypot_seq_if.slave  bus
);
  localparam int RW = W + 1;
  localparam int AW = 2 * RW;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [2:0] {
    IDLE, SQX, SQY, SQRT, FIN, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplr_q, mplr_d;
  logic [W-1:0]   y_q, y_d;
  logic           mode_q, mode_d;
  logic [RW-1:0]  root_q, root_d;
  logic [RW:0]    rem_q, rem_d;
  logic [RW-1:0]  result_q, result_d;
  logic           exact_q, exact_d;
  logic           out_valid_q, out_valid_d;

  logic           accept;
  logic           cnt_last_sq;
  logic           cnt_last_rt;
  logic [AW-1:0]  acc_add;
  logic [RW+2:0]  rem_sh;
  logic [RW+2:0]  trial;

  assign accept      = (state_q == IDLE) & ena & bus.in_valid;
  assign cnt_last_sq = (cnt_q == CW'(W - 1));
  assign cnt_last_rt = (cnt_q == CW'(RW - 1));
  assign acc_add     = mplr_q[0] ? (acc_q + AW'(mcand_q)) : acc_q;
  // During SQRT the accumulator doubles as the radicand, consumed two bits per cycle from the top.
  assign rem_sh      = {rem_q, acc_q[AW-1 -: 2]};
  assign trial       = {1'b0, root_q, 2'b01};

  // State register; ena low freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  // Next-state sequencing through square, root, finish and hand-off phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = SQX;
      SQX:     if (cnt_last_sq)   state_d = SQY;
      SQY:     if (cnt_last_sq)   state_d = SQRT;
      SQRT:    if (cnt_last_rt)   state_d = FIN;
      FIN:                        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.in_ready = (state_q == IDLE) & ena;
    bus.busy     = (state_q != IDLE);
  end

  // Datapath next values: operand capture, shift-add squaring, restoring root, rounding.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    y_d         = y_q;
    mode_d      = mode_q;
    root_d      = root_q;
    rem_d       = rem_q;
    result_d    = result_q;
    exact_d     = exact_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = '0;
          mcand_d = {{W{1'b0}}, bus.x};
          mplr_d  = bus.x;
          y_d     = bus.y;
          mode_d  = bus.mode;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      SQX, SQY: begin
        acc_d   = acc_add;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // The last x step reloads the multiplier with y so SQY sums onto x^2.
        if (cnt_last_sq) begin
          cnt_d = '0;
          if (state_q == SQX) begin
            mcand_d = {{W{1'b0}}, y_q};
            mplr_d  = y_q;
          end
        end
      end
      SQRT: begin
        acc_d = acc_q << 2;
        if (rem_sh >= trial) begin
          rem_d  = (RW+1)'(rem_sh - trial);
          root_d = {root_q[RW-2:0], 1'b1};
        end else begin
          rem_d  = (RW+1)'(rem_sh);
          root_d = {root_q[RW-2:0], 1'b0};
        end
        cnt_d = cnt_last_rt ? '0 : cnt_q + 1'b1;
      end
      FIN: begin
        // R > r is exactly S > (r + 0.5)^2 for integer S, so no tie handling is needed.
        result_d    = (mode_q && (rem_q > {1'b0, root_q})) ? root_q + 1'b1 : root_q;
        exact_d     = (rem_q == '0);
        out_valid_d = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset clears everything, ena low holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      root_q      <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      exact_q     <= exact_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.exact     = exact_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_hypot_seq.sv
// Directed bench for hypot_seq: W=8 and W=4 instances, hand-computed vectors,
// latency, backpressure, ena freeze and mid-operation reset.
module tb_hypot_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  always #5 clk = ~clk;

  hypot_seq_if #(.W(8)) b8 ();
  hypot_seq_if #(.W(4)) b4 ();

  hypot_seq #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(b8));
  hypot_seq #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(b4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start8(input logic [7:0] xv, input logic [7:0] yv, input logic m);
    @(negedge clk);
    b8.x = xv; b8.y = yv; b8.mode = m; b8.in_valid = 1'b1;
    check("in_ready8_before_accept", b8.in_ready, 1);
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    b8.x = 8'hA5; b8.y = 8'h5A; b8.mode = ~m;
  endtask

  task automatic wait_out8(input int lat0, output int l);
    bit got = 1'b0;
    l = lat0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (b8.out_valid === 1'b1) got = 1'b1;
    end
    if (!got) check("out_valid8_timeout", b8.out_valid, 1);
  endtask

  task automatic xfer8();
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b8.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid8_cleared", b8.out_valid, 0);
    check("in_ready8_after_xfer", b8.in_ready, 1);
  endtask

  task automatic op8(input logic [7:0] xv, input logic [7:0] yv, input logic m,
                     input int exp_r, input int exp_e);
    int l;
    start8(xv, yv, m);
    wait_out8(0, l);
    check($sformatf("result8 x=%0d y=%0d m=%0d", xv, yv, m), b8.result, exp_r);
    check($sformatf("exact8 x=%0d y=%0d m=%0d", xv, yv, m), b8.exact, exp_e);
    check($sformatf("latency8 x=%0d y=%0d", xv, yv), l, 26);
    xfer8();
  endtask

  task automatic op4(input logic [3:0] xv, input logic [3:0] yv, input logic m,
                     input int exp_r, input int exp_e);
    int  l = 0;
    bit  got = 1'b0;
    @(negedge clk);
    b4.x = xv; b4.y = yv; b4.mode = m; b4.in_valid = 1'b1;
    check("in_ready4_before_accept", b4.in_ready, 1);
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    b4.x = 4'h3;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (b4.out_valid === 1'b1) got = 1'b1;
    end
    if (!got) check("out_valid4_timeout", b4.out_valid, 1);
    check($sformatf("result4 m=%0d", m), b4.result, exp_r);
    check($sformatf("exact4 m=%0d", m), b4.exact, exp_e);
    check("latency4", l, 14);
    b4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b4.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid4_cleared", b4.out_valid, 0);
  endtask

  initial begin
    b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.mode = 1'b0; b8.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.x = '0; b4.y = '0; b4.mode = 1'b0; b4.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", b8.out_valid, 0);
    check("rst_result", b8.result, 0);
    check("rst_exact", b8.exact, 0);
    check("rst_busy", b8.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", b8.in_ready, 1);

    // Main function vectors
    op8(8'd3,   8'd4,   1'b0, 5,   1);
    op8(8'd255, 8'd255, 1'b0, 360, 0);
    op8(8'd255, 8'd255, 1'b1, 361, 0);
    op8(8'd2,   8'd3,   1'b0, 3,   0);
    op8(8'd2,   8'd3,   1'b1, 4,   0);
    op8(8'd1,   8'd2,   1'b1, 2,   0);
    op8(8'd0,   8'd0,   1'b0, 0,   1);
    op8(8'd0,   8'd7,   1'b1, 7,   1);

    // ena low in IDLE: no acceptance
    @(negedge clk);
    ena = 1'b0;
    b8.in_valid = 1'b1; b8.x = 8'd9; b8.y = 8'd9;
    #1;
    check("in_ready_ena_low", b8.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    ena = 1'b1;
    #1;
    check("busy_no_accept_ena_low", b8.busy, 0);

    // Backpressure: 5 stalled cycles with in_valid pulses
    start8(8'd5, 8'd12, 1'b0);
    wait_out8(0, lat);
    check("bp_latency", lat, 26);
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = 1'b1; b8.x = 8'(i + 1); b8.y = 8'd1;
      @(posedge clk);
      @(negedge clk);
      check("bp_result_stable", b8.result, 13);
      check("bp_exact_stable", b8.exact, 1);
      check("bp_out_valid_held", b8.out_valid, 1);
      check("bp_in_ready_low", b8.in_ready, 0);
    end
    b8.in_valid = 1'b0;
    xfer8();
    check("bp_no_queued_op", b8.busy, 0);
    @(negedge clk);
    check("bp_still_idle", b8.busy, 0);

    // ena freeze for 4 cycles in mid-SQRT (SQRT starts at edge 17)
    start8(8'd20, 8'd21, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    #1;
    check("freeze_in_ready", b8.in_ready, 0);
    check("freeze_busy", b8.busy, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("freeze_no_out_valid", b8.out_valid, 0);
    ena = 1'b1;
    wait_out8(24, lat);
    check("freeze_result", b8.result, 29);
    check("freeze_exact", b8.exact, 1);
    check("freeze_latency", lat, 30);
    xfer8();

    // Reset mid-operation, then a clean op
    start8(8'd100, 8'd100, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", b8.out_valid, 0);
    check("midrst_result", b8.result, 0);
    check("midrst_exact", b8.exact, 0);
    check("midrst_busy", b8.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", b8.in_ready, 1);
    op8(8'd6, 8'd8, 1'b0, 10, 1);

    // W=4 instance
    op4(4'd15, 4'd15, 1'b0, 21, 0);
    op4(4'd15, 4'd15, 1'b1, 21, 0);
    op4(4'd3,  4'd4,  1'b0, 5,  1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hypot_seq.md
Name: hypot_seq

Overview:
- Sequential Euclidean-magnitude unit: computes sqrt(x^2 + y^2) for two unsigned W-bit operands.
- Parametrised, multi-cycle successor to the single-cycle fixed-8-bit sum-of-squares/root block.
- Squaring uses shift-add; square root is bit-serial restoring, one result bit per cycle. No multipliers.
- Valid/ready handshakes on input and output, global ena freeze, runtime floor/round-to-nearest mode, and an exactness flag.

Parameters:
- W, 8, operand width in bits; legal range 2..16.
- RW, W+1, result width (derived, not overridable); covers sqrt(2)*(2^W-1) plus a round-up.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  global enable; low freezes every register.
- in_valid  input  1  operands presented.
- in_ready  output  1  combinational; equals (state==IDLE) & ena.
- x  input  W  unsigned operand.
- y  input  W  unsigned operand.
- mode  input  1  0 = floor(sqrt(S)); 1 = round-to-nearest; sampled with operands.
- out_valid  output  1  result available; held until accepted.
- out_ready  input  1  downstream accepts result.
- result  output  RW  magnitude.
- exact  output  1  1 when S is a perfect square.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, result=0, exact=0, busy=0, internal accumulators=0. An operation in progress is aborted and discarded.
- ena=0: no state, counter, datapath or output register changes. in_ready=0, so no input acceptance. Output transfer also requires ena=1.
- FSM: IDLE -> SQX -> SQY -> SQRT -> FIN -> DONE -> IDLE.
  - IDLE: on in_valid & in_ready, latch x, y, mode; clear accumulators; go to SQX. This edge is E0.
  - SQX: W cycles of shift-add on x; sq_x = x*x, 2W bits.
  - SQY: W cycles; S = sq_x + y*y, 2W+1 bits, no overflow possible.
  - SQRT: RW cycles, MSB first. Trial r|bit; keep the bit if the trial square <= S. Remainder R = S - r^2.
  - FIN: 1 cycle.
    - mode=1 and R > r: result = r+1; else result = r.
    - exact = (R==0).
    - Set out_valid; go to DONE.
  - DONE: hold result, exact, out_valid stable. On out_valid & out_ready & ena: clear out_valid, go to IDLE. result and exact keep their value until the next FIN or reset.
- Latency: out_valid is first high after edge E(3W+2) (26 cycles for W=8), with ena held high. Each ena-low cycle adds exactly one cycle.
- Throughput: one operation in flight. New operands are accepted only in IDLE; the earliest is the cycle after the output transfer.
- in_valid outside IDLE is ignored; nothing is queued.
- mode=1 ties cannot occur: S is an integer, so S is never exactly (r+0.5)^2.
- Round-up never exceeds RW bits. For W=8 the maximum result is 361.
- x=0 and/or y=0 need no special case; the datapath yields |other operand|, exact=1.
- Changes on x, y or mode after acceptance have no effect.

Test Plan:
- W=8, x=3, y=4, mode=0 -> result=5, exact=1; out_valid first high 26 cycles after the accept edge.
- x=255, y=255: mode=0 -> result=360, exact=0; mode=1 -> result=361, exact=0.
- x=2, y=3 (S=13): mode=0 -> 3; mode=1 -> 4. x=1, y=2 (S=5): mode=1 -> 2. x=0, y=0 -> 0, exact=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> result/exact stable and in_ready=0. in_valid pulses during the stall are not accepted. Transfer happens on the first out_ready-high edge.
- ena low for 4 cycles in mid-SQRT -> all state frozen; result correct; latency = 30 cycles.
- Reset pulse at cycle 10 of an operation -> all outputs 0 immediately; in_ready=1 after release. Next op x=6, y=8 -> 10, exact=1. Repeat with W=4: x=15, y=15 -> mode0 21, mode1 21, latency 14.
